operand_capture_reader: RTL and testbench

Board-level consumer of switch data for the DE2 Exercise 3 series. It captures an 8-bit operand A from SW on the first debounced press of a pushbutton and operand B on the second press. It shows A and B in hex on four 7-segment displays and shows A+B on the red LEDs. The pushbutton path is synchronised and debounced in CLOCK_50, so capture is edge-triggered and clean rather than level-sensitive.

---
 rtl/operand_capture_pkg.sv | 22 ++
 rtl/operand_capture_reader_hex7seg.sv | 14 +
 rtl/operand_capture_reader.sv | 153 +++++++++++++++
 tb/tb_operand_capture_reader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/operand_capture_pkg.sv
// Shared state encoding and 7-segment constants for operand_capture_reader.
package operand_capture_pkg;

    // One-hot-ish state code, driven straight onto LEDG.
    typedef enum logic [1:0] {
        S_A    = 2'b01,
        S_B    = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned SEG_W = 7;

    // Active-low segments, bit0 = segment a.
    localparam logic [SEG_W-1:0] SEG_ZERO = 7'h40;

    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/operand_capture_reader_hex7seg.sv
// Nibble to active-low 7-segment decoder (table lookup).
module hex7seg
    import operand_capture_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_o
);

    // Pure table lookup; no state.
    always_comb begin
        seg_o = HEX_SEG[nib_i];
    end

endmodule

// File: rtl/operand_capture_reader.sv
// Captures operand A then B from SW on debounced presses of Load_n,
// shows them on HEX3..HEX0 and their 9-bit sum on LEDR.
// Optional build macro: LIVE_SW_VIEW_EN (HEX previews live SW for the
// operand about to be captured).
module operand_capture_reader
    import operand_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic [OP_W-1:0]  SW,
    input  logic             Load_n,
    output logic [SEG_W-1:0] HEX3,
    output logic [SEG_W-1:0] HEX2,
    output logic [SEG_W-1:0] HEX1,
    output logic [SEG_W-1:0] HEX0,
    output logic [OP_W:0]    LEDR,
    output logic [1:0]       LEDG
);

    logic             sync1_q, sync2_q;
    logic [1:0]       fill_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             load_p_q, load_p_d;
    logic             ld_s;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OP_W:0]    ledr_q, ledr_d;

    assign ld_s = sync2_q;

    // Debounce counter, pulse generation and post-reset arming.
    // armed_q blocks the press edge until a real released sample has been
    // seen, so a button held through reset cannot capture.
    always_comb begin
        deb_d    = deb_q;
        cnt_d    = '0;
        armed_d  = armed_q | (fill_q[1] & ld_s & deb_q);
        load_p_d = armed_q & deb_prev_q & ~deb_q;
        if (ld_s != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = ld_s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce and edge-detect registers.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            fill_q     <= 2'b00;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            load_p_q   <= 1'b0;
        end else begin
            sync1_q    <= Load_n;
            sync2_q    <= sync1_q;
            fill_q     <= {fill_q[0], 1'b1};
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            load_p_q   <= load_p_d;
        end
    end

    // Capture sequencing: A, then B, then restart with a new A.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ledr_d  = ledr_q;
        case (state_q)
            S_A: begin
                if (load_p_q) begin
                    a_d     = SW;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (load_p_q) begin
                    b_d     = SW;
                    ledr_d  = {1'b0, a_q} + {1'b0, SW};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (load_p_q) begin
                    a_d     = SW;
                    b_d     = '0;
                    ledr_d  = '0;
                    state_d = S_B;
                end
            end
            default: begin
                state_d = S_A;
                ledr_d  = '0;
            end
        endcase
    end

    // Operand, state and sum registers.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            ledr_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ledr_q  <= ledr_d;
        end
    end

    logic [OP_W-1:0] show_a, show_b;

`ifdef LIVE_SW_VIEW_EN
    // Preview live SW for whichever operand the next press will capture.
    always_comb begin
        show_a = (state_q == S_A) ? SW : a_q;
        show_b = (state_q == S_B) ? SW : b_q;
    end
`else
    // Display the captured operands only.
    always_comb begin
        show_a = a_q;
        show_b = b_q;
    end
`endif

    hex7seg u_hex3 (.nib_i(show_a[7:4]), .seg_o(HEX3));
    hex7seg u_hex2 (.nib_i(show_a[3:0]), .seg_o(HEX2));
    hex7seg u_hex1 (.nib_i(show_b[7:4]), .seg_o(HEX1));
    hex7seg u_hex0 (.nib_i(show_b[3:0]), .seg_o(HEX0));

    assign LEDR = ledr_q;
    assign LEDG = state_q;

endmodule

// File: tb/tb_operand_capture_reader.sv
// Directed bench for operand_capture_reader with DEBOUNCE_CYCLES = 4.
module tb_operand_capture_reader;

    logic       CLOCK_50;
    logic       Resetn;
    logic [7:0] SW;
    logic       Load_n;
    logic [6:0] HEX3, HEX2, HEX1, HEX0;
    logic [8:0] LEDR;
    logic [1:0] LEDG;

    int total = 0;
    int bad   = 0;

    operand_capture_reader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .Resetn  (Resetn),
        .SW      (SW),
        .Load_n  (Load_n),
        .HEX3    (HEX3),
        .HEX2    (HEX2),
        .HEX1    (HEX1),
        .HEX0    (HEX0),
        .LEDR    (LEDR),
        .LEDG    (LEDG)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick(3);
        Resetn = 1'b1;
        tick(2);
    endtask

    // Clean press long enough to capture, then a clean release.
    task automatic press(input logic [7:0] sw);
        SW     = sw;
        Load_n = 1'b0;
        tick(12);
        Load_n = 1'b1;
        tick(12);
    endtask

    task automatic check_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                             input logic [6:0] h1, input logic [6:0] h0);
        check_eq({tag, "_hex3"}, 32'(HEX3), 32'(h3));
        check_eq({tag, "_hex2"}, 32'(HEX2), 32'(h2));
        check_eq({tag, "_hex1"}, 32'(HEX1), 32'(h1));
        check_eq({tag, "_hex0"}, 32'(HEX0), 32'(h0));
    endtask

    initial begin
        int n;
        Resetn = 1'b0;
        Load_n = 1'b1;
        SW     = 8'h00;
        tick(2);
        check_eq("rst_ledg", 32'(LEDG), 32'h1);
        check_eq("rst_ledr", 32'(LEDR), 32'h0);
        Resetn = 1'b1;

        // 1: idle after reset
        tick(20);
        check_hex("idle", 7'h40, 7'h40, 7'h40, 7'h40);
        check_eq("idle_ledr", 32'(LEDR), 32'h0);
        check_eq("idle_ledg", 32'(LEDG), 32'h1);

        // 2: clean press, latency 2 + 4 + 1 + 1 edges
        SW     = 8'h3C;
        Load_n = 1'b0;
        n = 0;
        while (n < 50 && LEDG != 2'b10) begin
            tick(1);
            n++;
        end
        check_eq("press_latency", 32'(n), 32'd8);
        tick(22);
        Load_n = 1'b1;
        tick(12);
        check_hex("capA", 7'h30, 7'h46, 7'h40, 7'h40);
        check_eq("capA_ledg", 32'(LEDG), 32'h2);
        check_eq("capA_ledr", 32'(LEDR), 32'h0);

        // 3: bouncy press yields a single capture into A
        do_reset();
        SW = 8'hA7;
        for (int i = 0; i < 12; i++) begin
            Load_n = (i % 4) >= 2;
            tick(1);
        end
        Load_n = 1'b0;
        tick(30);
        Load_n = 1'b1;
        tick(12);
        check_eq("bounce_ledg", 32'(LEDG), 32'h2);
        check_hex("bounce", 7'h08, 7'h78, 7'h40, 7'h40);

        // 4: FF + FF, carry kept in LEDR[8]
        do_reset();
        press(8'hFF);
        check_eq("ffA_ledg", 32'(LEDG), 32'h2);
        check_eq("ffA_ledr", 32'(LEDR), 32'h0);
        press(8'hFF);
        check_eq("ffB_ledg", 32'(LEDG), 32'h3);
        check_eq("ffB_ledr", 32'(LEDR), 32'h1FE);
        check_hex("ffB", 7'h0E, 7'h0E, 7'h0E, 7'h0E);

        // 5: press in S_DONE restarts with new A and clears B and LEDR
        press(8'h05);
        check_eq("restart_ledg", 32'(LEDG), 32'h2);
        check_eq("restart_ledr", 32'(LEDR), 32'h0);
        check_hex("restart", 7'h40, 7'h12, 7'h40, 7'h40);

        // 6: reset in S_B with the button held; held release gives no capture
        SW     = 8'h77;
        Load_n = 1'b0;
        tick(3);
        Resetn = 1'b0;
        tick(3);
        check_eq("midrst_ledg", 32'(LEDG), 32'h1);
        check_hex("midrst", 7'h40, 7'h40, 7'h40, 7'h40);
        Resetn = 1'b1;
        tick(30);
        check_eq("held_ledg", 32'(LEDG), 32'h1);
        check_eq("held_hex2", 32'(HEX2), 32'h40);
        Load_n = 1'b1;
        tick(12);
        check_eq("held_rel_ledg", 32'(LEDG), 32'h1);
        press(8'h5A);
        check_eq("repress_ledg", 32'(LEDG), 32'h2);
        check_hex("repress", 7'h12, 7'h08, 7'h40, 7'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
